// File: rtl/alu_seq_pkg.sv
// Shared types for the registered ALU: opcode encoding, flag bit positions
// and the multiplier sequencing states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADC   = 4'd1,
    OP_SUB   = 4'd2,
    OP_SBB   = 4'd3,
    OP_PASSA = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NOT   = 4'd8,
    OP_SHL1  = 4'd9,
    OP_SHR1  = 4'd10,
    OP_ASR1  = 4'd11,
    OP_MUL   = 4'd12,
    OP_RSVD  = 4'd13
  } op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per clock. done is high
// during the final step; product then carries the completed a*b.
module mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     partial;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    product = {partial, acc[WIDTH-1:1]};
  end

  assign done = busy && (cnt == CW'(WIDTH - 1));

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end
  end

  // NOTE: the datapath registers are not reset; they are always loaded on
  // start before anything reads them, so a reset would only cost routing.
  always_ff @(posedge Clk) begin
    if (busy) begin
      acc <= product;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end
  end

endmodule

// File: rtl/alu_seq_n.sv
// Registered ALU with Start/Busy/Done handshake and Z/N/V/C flag register.
// Define ALU_SEQ_MUL_EN to build the multi-cycle unsigned multiplier (op 12).
module alu_seq_n
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FW    = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             En,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Hi,
  output logic [FW-1:0]    F
);

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  op_e                op;
  logic               accept, is_mul, cin;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   alu_q;
  logic               alu_c, alu_v;
  logic [FW-1:0]      alu_flags, mul_flags;
  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_fin, mul_en;

  assign op     = op_e'(Op);
  assign accept = Start & ~Busy;
  assign is_mul = MUL_EN && (op == OP_MUL);
  assign cin    = F[FLAG_C];

  always_comb begin
    wide  = '0;
    alu_q = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        wide  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (op == OP_ADC) & cin};
        alu_q = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
        alu_v = alu_c ^ A[WIDTH-1] ^ B[WIDTH-1] ^ alu_q[WIDTH-1];
      end
      OP_SUB, OP_SBB: begin
        // C is a borrow, i.e. the inverted adder carry of A+~B+1, so the
        // overflow term folds ~B and ~carry back into plain B and borrow.
        wide  = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, (op == OP_SBB) & cin};
        alu_q = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
        alu_v = alu_c ^ A[WIDTH-1] ^ B[WIDTH-1] ^ alu_q[WIDTH-1];
      end
      OP_PASSA: alu_q = A;
      OP_AND:   alu_q = A & B;
      OP_OR:    alu_q = A | B;
      OP_XOR:   alu_q = A ^ B;
      OP_NOT:   alu_q = ~A;
      OP_SHL1: begin
        alu_q = {A[WIDTH-2:0], 1'b0};
        alu_c = A[WIDTH-1];
      end
      OP_SHR1: begin
        alu_q = {1'b0, A[WIDTH-1:1]};
        alu_c = A[0];
      end
      OP_ASR1: begin
        alu_q = {A[WIDTH-1], A[WIDTH-1:1]};
        alu_c = A[0];
      end
      default: alu_q = '0;
    endcase
  end

  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_Z] = ~|alu_q;
    alu_flags[FLAG_N] = alu_q[WIDTH-1];
    alu_flags[FLAG_V] = alu_v;
    alu_flags[FLAG_C] = alu_c;
  end

  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = ~|mul_prod;
    mul_flags[FLAG_N] = mul_prod[2*WIDTH-1];
    mul_flags[FLAG_V] = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flags[FLAG_C] = |mul_prod[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      Q    <= '0;
      Hi   <= '0;
      F    <= '0;
      Done <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept && !is_mul) begin
        Q    <= alu_q;
        Hi   <= '0;
        Done <= 1'b1;
        if (En) F <= alu_flags;
      end else if (mul_fin) begin
        Q    <= mul_prod[WIDTH-1:0];
        Hi   <= mul_prod[2*WIDTH-1:WIDTH];
        Done <= 1'b1;
        if (mul_en) F <= mul_flags;
      end
    end
  end

`ifdef ALU_SEQ_MUL_EN
  state_e state_q, state_d;
  logic   mul_busy, mul_done, en_q;

  mul_seq #(.WIDTH(WIDTH)) u_mul (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // En must survive the whole multiply, since the inputs are free after Start.
  always_ff @(posedge Clk) begin
    if (accept && is_mul) en_q <= En;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL_RUN;
      MUL_RUN: if (mul_done)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy    = mul_busy;
  assign mul_fin = mul_done && (state_q == MUL_RUN);
  assign mul_en  = en_q;
`else
  assign Busy     = 1'b0;
  assign mul_fin  = 1'b0;
  assign mul_en   = 1'b0;
  assign mul_prod = '0;
`endif

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n: arithmetic reference model plus directed
// vectors; the multiplier checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq_n;

  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         En = 1'b0;
  logic [3:0]   Op = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy, Done;
  logic [W-1:0] Q, Hi;
  logic [15:0]  F;

  alu_seq_n #(.WIDTH(W), .FW(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .En      (En),
    .Busy    (Busy),
    .Done    (Done),
    .Q       (Q),
    .Hi      (Hi),
    .F       (F)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic check_v(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [15:0] q;
    logic [15:0] hi;
    logic [15:0] f;
  } res_t;

  function automatic res_t model_op(logic [3:0] op, logic [15:0] a, logic [15:0] b, logic cin);
    res_t r;
    int ua, ub, sa, sb, ur, sr;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    ur = 0; sr = 0; c = 1'b0; v = 1'b0;
    r = '0;
    case (op)
      4'd0:  begin ur = ua + ub;        sr = sa + sb;        c = (ur > 65535); end
      4'd1:  begin ur = ua + ub + int'(cin); sr = sa + sb + int'(cin); c = (ur > 65535); end
      4'd2:  begin ur = ua - ub;        sr = sa - sb;        c = (ur < 0); end
      4'd3:  begin ur = ua - ub - int'(cin); sr = sa - sb - int'(cin); c = (ur < 0); end
      4'd4:  ur = ua;
      4'd5:  ur = int'(a & b);
      4'd6:  ur = int'(a | b);
      4'd7:  ur = int'(a ^ b);
      4'd8:  ur = int'(~a);
      4'd9:  begin ur = ua << 1;  c = a[15]; end
      4'd10: begin ur = ua >> 1;  c = a[0]; end
      4'd11: begin ur = sa >>> 1; c = a[0]; end
      default: ur = 0;
    endcase
    if (op <= 4'd3) v = (sr > 32767) || (sr < -32768);
    r.q = 16'(ur);
    r.f = {12'b0, c, v, r.q[15], r.q == 16'h0};
    return r;
  endfunction

  function automatic res_t model_mul(logic [15:0] a, logic [15:0] b);
    res_t r;
    longint p;
    p = longint'(a) * longint'(b);
    r.q  = 16'(p);
    r.hi = 16'(p >> 16);
    r.f  = {12'b0, r.hi != 0, r.hi != 0, r.hi[15], p == 0};
    return r;
  endfunction

  logic [15:0] m_q, m_hi, m_f, m_a, m_b;
  logic        m_done, m_en;
  int          m_left;
  res_t        alu_r, mul_r;

  always_comb begin
    alu_r = model_op(Op, A, B, m_f[3]);
    mul_r = model_mul(m_a, m_b);
  end

  always @(posedge Clk) begin
    if (!Reset_n) begin
      m_q    <= '0;
      m_hi   <= '0;
      m_f    <= '0;
      m_done <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_q    <= mul_r.q;
          m_hi   <= mul_r.hi;
          m_done <= 1'b1;
          if (m_en) m_f <= mul_r.f;
        end
      end else if (Start) begin
        if (MUL_EN && Op == 4'd12) begin
          m_left <= W;
          m_a    <= A;
          m_b    <= B;
          m_en   <= En;
        end else begin
          m_q    <= alu_r.q;
          m_hi   <= '0;
          m_done <= 1'b1;
          if (En) m_f <= alu_r.f;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_on) begin
      check_b("cmp_done", Done, m_done);
      check_b("cmp_busy", Busy, m_left != 0);
      check_v("cmp_q", Q, m_q);
      check_v("cmp_hi", Hi, m_hi);
      check_v("cmp_f", F, m_f);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic en);
    Op = op; A = a; B = b; En = en; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [15:0] q, input logic [15:0] f);
    check_b({name, "_done"}, Done, 1'b1);
    check_v({name, "_q"}, Q, q);
    check_v({name, "_f"}, F, f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;

    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    cmp_on = 1'b1;
    check_b("rst_busy", Busy, 1'b0);
    check_b("rst_done", Done, 1'b0);
    check_v("rst_q", Q, 16'h0000);
    check_v("rst_hi", Hi, 16'h0000);
    check_v("rst_f", F, 16'h0000);
    Reset_n = 1'b1;
    @(negedge Clk);

    issue(4'd0, 16'h7FFF, 16'h0001, 1'b1); expect_res("add_ovf", 16'h8000, 16'h0006);
    check_v("add_ovf_hi", Hi, 16'h0000);
    issue(4'd2, 16'h0003, 16'h0005, 1'b1); expect_res("sub_neg", 16'hFFFE, 16'h000A);
    issue(4'd0, 16'hFFFF, 16'h0001, 1'b1); expect_res("add_carry", 16'h0000, 16'h0009);
    issue(4'd1, 16'h0000, 16'h0000, 1'b1); expect_res("adc_chain", 16'h0001, 16'h0000);
    @(negedge Clk);
    check_b("idle_done", Done, 1'b0);
    check_v("idle_q_hold", Q, 16'h0001);

    issue(4'd0, 16'hFFFF, 16'h0001, 1'b1); expect_res("add_carry2", 16'h0000, 16'h0009);
    issue(4'd7, 16'h00FF, 16'h00FF, 1'b0); expect_res("xor_noen", 16'h0000, 16'h0009);
    issue(4'd3, 16'h0005, 16'h0002, 1'b1); expect_res("sbb_cin", 16'h0002, 16'h0000);
    issue(4'd9, 16'h8001, 16'h0000, 1'b1); expect_res("shl1", 16'h0002, 16'h0008);
    issue(4'd11, 16'h8003, 16'h0000, 1'b1); expect_res("asr1", 16'hC001, 16'h000A);
    issue(4'd10, 16'h8003, 16'h0000, 1'b1); expect_res("shr1", 16'h4001, 16'h0008);
    issue(4'd8, 16'hFFFF, 16'h0000, 1'b1); expect_res("not", 16'h0000, 16'h0001);
    issue(4'd6, 16'h1200, 16'h0034, 1'b1); expect_res("or", 16'h1234, 16'h0000);
    issue(4'd14, 16'h0005, 16'h0003, 1'b1); expect_res("rsvd14", 16'h0000, 16'h0001);

    for (int i = 0; i < 24; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'd12) op = 4'd5;
      issue(op, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    issue(4'd0, 16'hFFFF, 16'h0001, 1'b1);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check_v("rst2_f", F, 16'h0000);
    check_v("rst2_q", Q, 16'h0000);
    @(negedge Clk);

`ifdef ALU_SEQ_MUL_EN
    issue(4'd12, 16'h1234, 16'h0010, 1'b1);
    check_b("mul_busy", Busy, 1'b1);
    check_b("mul_nodone", Done, 1'b0);
    n = 0;
    while (!Done && n < 40) begin
      if (n == 3) begin
        Op = 4'd0; A = 16'h0001; B = 16'h0001; En = 1'b1; Start = 1'b1;
      end
      if (n == 4) Start = 1'b0;
      @(negedge Clk);
      n++;
    end
    check_v("mul_latency", 16'(n), 16'd16);
    check_v("mul_hi", Hi, 16'h0001);
    expect_res("mul", 16'h2340, 16'h000C);
    check_b("mul_busy_end", Busy, 1'b0);
    @(negedge Clk);

    issue(4'd12, 16'hFFFF, 16'hFFFF, 1'b1);
    repeat (4) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check_b("mulrst_busy", Busy, 1'b0);
    check_b("mulrst_done", Done, 1'b0);
    check_v("mulrst_q", Q, 16'h0000);
    check_v("mulrst_hi", Hi, 16'h0000);
    check_v("mulrst_f", F, 16'h0000);
    pulses = 0;
    repeat (20) begin
      @(negedge Clk);
      if (Done) pulses++;
    end
    check_v("mulrst_no_done", 16'(pulses), 16'd0);
`else
    issue(4'd12, 16'h1234, 16'h0010, 1'b1);
    expect_res("mul_rsvd", 16'h0000, 16'h0001);
    check_v("mul_rsvd_hi", Hi, 16'h0000);
    check_b("mul_rsvd_busy", Busy, 1'b0);
    n = 0;
    pulses = 0;
`endif

    repeat (3) @(negedge Clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_n.md
Name: alu_seq_n

Overview:
Parametrised registered ALU, successor to the combinational adder/ALU datapath. Operands and opcode are accepted on a Start/Busy/Done handshake. Q and a flag register F (Z, N, V, C) are registered, and a stored carry enables multi-word ADC/SBB chains. An optional sequential shift-add multiplier occupies Busy for WIDTH cycles. It sits between the register file read ports and the writeback/flags path of the processor.

Parameters:
WIDTH, 16, operand/result width (>= 4)
FW, 16, flag register width; bits [FW-1:4] always 0

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  reset; synchronous and active-low
Start  in  1  request; sampled only when Busy=0
Op  in  4  opcode, sampled with Start
A  in  WIDTH  operand A, sampled with Start
B  in  WIDTH  operand B, sampled with Start
En  in  1  flag-update enable, sampled with Start
Busy  out  1  multi-cycle op in progress
Done  out  1  one-cycle pulse: Q/Hi/F valid
Q  out  WIDTH  result (low half for MUL)
Hi  out  WIDTH  high half of MUL product; 0 for other ops
F  out  FW  flags: F[0]=Z, F[1]=N, F[2]=V, F[3]=C

Behaviour:
- Reset (Reset_n=0 at a rising edge): Busy=0, Done=0, Q=0, Hi=0, F=0, stored carry=0, multiplier aborted. Reset takes priority over every other event, including mid-MUL.
- Opcodes:
  - 0 ADD: {C,Q}=A+B
  - 1 ADC: A+B+F[3]
  - 2 SUB: {C,Q}=A-B, C=borrow
  - 3 SBB: A-B-F[3]
  - 4 PASSA
  - 5 AND, 6 OR, 7 XOR
  - 8 NOT A
  - 9 SHL1: C=A[W-1]
  - 10 SHR1 logical: C=A[0]
  - 11 ASR1: C=A[0]
  - 12 MUL: unsigned, {Hi,Q}=A*B
  - 13-15: Q=0, flags computed normally
- Flags:
  - Z=~|Q; N=Q[W-1].
  - V = C^A[W-1]^B'[W-1]^Q[W-1] for ADD/ADC/SUB/SBB, where B' = B for add and ~B for subtract.
  - V=0 for logic, shift and pass ops.
  - C=0 for logic and pass ops.
  - MUL: Z=~|{Hi,Q}, N=Hi[W-1], C=V=(Hi!=0).
- Single-cycle ops: Start=1 and Busy=0 at edge t → after edge t, Q/Hi valid and Done=1 for exactly one cycle. Busy stays 0, so back-to-back Start every cycle is legal with throughput 1/cycle.
- MUL: Start at edge t → Busy=1 after edge t. One shift-add step per edge. After edge t+WIDTH: Done=1, Busy=0, Q/Hi valid. Latency WIDTH cycles.
- Start while Busy=1 is ignored; no queueing; A/B/Op are don't-care.
- Flags: F updates on the Done edge only if the En sampled with Start was 1; otherwise F holds.
- Stored carry for ADC/SBB is F[3] at the time Start is sampled. ADC/SBB are single-cycle, so consecutive ops see the prior result's carry.
- Q/Hi hold their value between Done pulses.

State machine:
- States: IDLE, MUL_RUN.
- IDLE --(Start & Op==12)--> MUL_RUN.
- MUL_RUN --(count==WIDTH-1)--> IDLE with Done.
- Any state --(reset)--> IDLE.

Optional Feature:
Macro ALU_SEQ_MUL_EN.
- Defined: MUL implemented as above; mul_seq instantiated.
- Undefined: Op 12 behaves as a reserved opcode (single-cycle, Q=0, Hi=0, Z=1, N=V=C=0). Busy is tied 0; no multiplier logic is present.

Decomposition:
- Package alu_seq_pkg:
  - op_e enum (ADD..MUL, RSVD)
  - flag index constants FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3
  - state_e {IDLE, MUL_RUN}
- Sub-module mul_seq (WIDTH): start/a/b in; busy/done/product[2W-1:0] out; shift-add, one bit per cycle; same Clk/Reset_n.
- Top: opcode decode, single-cycle datapath, flag logic and registers, handshake.

Test Plan:
- ADD A=0x7FFF B=0x0001 En=1 → one cycle later Done=1, Q=0x8000, F[3:0]: Z=0 N=1 V=1 C=0.
- SUB A=0x0003 B=0x0005 En=1 → Q=0xFFFE, C=1, N=1, V=0, Z=0.
- ADD 0xFFFF+0x0001 (En=1) → Q=0x0000, Z=1, C=1; next cycle ADC A=0 B=0 → Q=0x0001, C=0.
- XOR A=0x00FF B=0x00FF with En=0 after a flag-setting op → Q=0x0000, F unchanged.
- MUL A=0x1234 B=0x0010 (macro defined) → Busy 16 cycles, Done at edge t+16, Q=0x2340, Hi=0x0001, C=V=1. A Start issued during Busy is ignored.
- Reset_n=0 for one edge during MUL cycle 5 → Busy=0, Done=0, Q=0, Hi=0, F=0 after that edge, and no Done pulse follows.
